// File: rtl/button_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : button_debounce
//  Purpose  : Debounces a raw, active-low, bouncing pushbutton. Produces a
//             clean level, one-cycle press / release strobes, an optional
//             auto-repeat strobe while the button is held, a combined step
//             strobe for a downstream counter and an 8-bit press counter.
//
//  Ports    : clk           - system clock, rising-edge logic
//             rst_n         - synchronous, active-low reset
//             btn_n         - raw asynchronous button, low = pressed
//             btn_level     - debounced level, 1 = pressed
//             press_pulse   - one-cycle strobe on an accepted press
//             release_pulse - one-cycle strobe on an accepted release
//             repeat_pulse  - one-cycle strobe per auto-repeat while held
//             step_pulse    - press_pulse | repeat_pulse
//             press_count   - accepted presses modulo 256
//
//  Config   : define BUTTON_AUTOREPEAT_EN to build the auto-repeat timer.
//             When undefined, repeat_pulse is held at 0 and no timer exists.
//
//  Revision : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 240000,   // stable cycles to accept a change
    parameter int REPEAT_DELAY    = 6000000,  // press to first repeat, in cycles
    parameter int REPEAT_PERIOD   = 1200000   // repeat to repeat, in cycles
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_n,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       repeat_pulse,
    output logic       step_pulse,
    output logic [7:0] press_count
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_TERM = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] c_S_IDLE       = 2'd0;
    localparam logic [1:0] c_S_PRESS_WAIT = 2'd1;
    localparam logic [1:0] c_S_PRESSED    = 2'd2;
    localparam logic [1:0] c_S_REL_WAIT   = 2'd3;

    // ------------------------------------------------------------------------
    // Input synchronizer. Both flops reset to 1 so a reset looks "released".
    // ------------------------------------------------------------------------
    logic r_sync1;
    logic r_sync2;
    logic w_pressed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    assign w_pressed = ~r_sync2;

    // ------------------------------------------------------------------------
    // FSM: state register
    // r_prev_state lets the output stage decode state *entry*, so each
    // accepted transition yields exactly one registered strobe one cycle
    // after the state register itself moves.
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         r_prev_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         w_state_nx;
    logic [c_CNT_W-1:0] w_cnt_nx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_S_IDLE;
            r_prev_state <= c_S_IDLE;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_prev_state <= r_state;
            r_cnt        <= w_cnt_nx;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state and stable-counter logic
    // The counter stops at its terminal value (the transition fires there),
    // so it can never wrap.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        case (r_state)
            c_S_IDLE: begin
                if (w_pressed) begin
                    w_state_nx = c_S_PRESS_WAIT;
                    w_cnt_nx   = '0;
                end
            end
            c_S_PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_nx = c_S_IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_CNT_TERM) begin
                    w_state_nx = c_S_PRESSED;
                end else begin
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            c_S_PRESSED: begin
                if (!w_pressed) begin
                    w_state_nx = c_S_REL_WAIT;
                    w_cnt_nx   = '0;
                end
            end
            c_S_REL_WAIT: begin
                if (w_pressed) begin
                    // Release was only a glitch: back to held, no strobe.
                    w_state_nx = c_S_PRESSED;
                    w_cnt_nx   = '0;
                end else if (r_cnt == c_CNT_TERM) begin
                    w_state_nx = c_S_IDLE;
                end else begin
                    w_cnt_nx   = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nx = c_S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Auto-repeat timer (optional)
    // Down-counter loaded with REPEAT_DELAY on the press acceptance. It only
    // runs while in PRESSED, so it is frozen during REL_WAIT and resumes if
    // the release is aborted. On reaching zero it fires and reloads with
    // REPEAT_PERIOD-1 so that the next hit is REPEAT_PERIOD cycles later.
    // ------------------------------------------------------------------------
    logic w_rpt_hit;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int c_RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                              : REPEAT_PERIOD;
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    logic [c_RPT_W-1:0] r_rpt;
    logic               w_rpt_load;

    assign w_rpt_load = (r_state == c_S_PRESS_WAIT) && (w_state_nx == c_S_PRESSED);
    assign w_rpt_hit  = (r_state == c_S_PRESSED) && (r_rpt == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rpt <= '0;
        end else if (w_rpt_load) begin
            r_rpt <= c_RPT_W'(REPEAT_DELAY);
        end else if (r_state == c_S_PRESSED) begin
            if (r_rpt == '0) begin
                r_rpt <= c_RPT_W'(REPEAT_PERIOD - 1);
            end else begin
                r_rpt <= r_rpt - 1'b1;
            end
        end
    end
`else
    // Repeat parameters are accepted but have no effect in this build.
    logic w_unused_rpt_cfg;
    assign w_unused_rpt_cfg = (REPEAT_DELAY > 0) ^ (REPEAT_PERIOD > 0);
    assign w_rpt_hit        = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: output decode (next values of the registered outputs)
    // ------------------------------------------------------------------------
    logic       w_press_nx;
    logic       w_release_nx;
    logic       w_repeat_nx;
    logic       w_level_nx;
    logic [7:0] w_count_nx;
    logic       r_level;
    logic       r_press;
    logic       r_release;
    logic       r_repeat;
    logic       r_step;
    logic [7:0] r_count;

    always_comb begin
        w_press_nx   = (r_state == c_S_PRESSED) && (r_prev_state == c_S_PRESS_WAIT);
        w_release_nx = (r_state == c_S_IDLE)    && (r_prev_state == c_S_REL_WAIT);
        // A repeat can never coincide with the press strobe; guard anyway so
        // the three strobes stay mutually exclusive for any parameter set.
        w_repeat_nx  = w_rpt_hit && !w_press_nx;
        w_level_nx   = r_level;
        w_count_nx   = r_count;
        if (w_press_nx) begin
            w_level_nx = 1'b1;
            w_count_nx = r_count + 8'd1;   // wraps 255 -> 0 naturally
        end else if (w_release_nx) begin
            w_level_nx = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_repeat  <= 1'b0;
            r_step    <= 1'b0;
            r_count   <= 8'd0;
        end else begin
            r_level   <= w_level_nx;
            r_press   <= w_press_nx;
            r_release <= w_release_nx;
            r_repeat  <= w_repeat_nx;
            r_step    <= w_press_nx | w_repeat_nx;
            r_count   <= w_count_nx;
        end
    end

    assign btn_level     = r_level;
    assign press_pulse   = r_press;
    assign release_pulse = r_release;
    assign repeat_pulse  = r_repeat;
    assign step_pulse    = r_step;
    assign press_count   = r_count;

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_button_debounce
//  Purpose  : Self-checking bench for button_debounce with DEBOUNCE_CYCLES=4,
//             REPEAT_DELAY=10, REPEAT_PERIOD=3. Expected strobes are queued
//             with the clock edge they must follow; a negedge monitor pops
//             and compares them. Level / count are checked per table vector.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

    localparam int c_DEB = 4;
    localparam int c_LAT = c_DEB + 3;   // edges from first low sample to strobe

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_n;
    logic       btn_level;
    logic       press_pulse;
    logic       release_pulse;
    logic       repeat_pulse;
    logic       step_pulse;
    logic [7:0] press_count;

    button_debounce #(
        .DEBOUNCE_CYCLES (c_DEB),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_n         (btn_n),
        .btn_level     (btn_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .repeat_pulse  (repeat_pulse),
        .step_pulse    (step_pulse),
        .press_count   (press_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;     // number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 1'b0;

    // Strobe kinds: 1 press, 2 release, 3 repeat
    typedef struct {
        int cyc;
        int kind;
    } exp_t;
    exp_t q[$];

    typedef struct {
        bit btn;
        int hold;
        bit exp_press;
        bit exp_rel;
        bit exp_level;
        int exp_count;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_at(input int c, input int k);
        exp_t e;
        e.cyc  = c;
        e.kind = k;
        q.push_back(e);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (mon_en) begin
            int act;
            int nhi;
            act = 0;
            if (press_pulse)   act = 1;
            if (release_pulse) act = 2;
            if (repeat_pulse)  act = 3;
            nhi = int'(press_pulse) + int'(release_pulse) + int'(repeat_pulse);
            check("strobe_onehot", int'(nhi <= 1), 1);
            check("step_pulse", int'(step_pulse), int'(press_pulse | repeat_pulse));
            while (q.size() > 0 && q[0].cyc < cyc) begin
                check("missed_strobe", 0, q[0].kind);
                void'(q.pop_front());
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                check("strobe_kind", act, q[0].kind);
                void'(q.pop_front());
            end else begin
                check("no_strobe", act, 0);
            end
        end
    end

    initial begin
        int c0;
        int c1;

        vecs[0] = '{1'b1, 20, 1'b0, 1'b0, 1'b0, 0};   // idle after reset
        vecs[1] = '{1'b0, 12, 1'b1, 1'b0, 1'b1, 1};   // clean press
        vecs[2] = '{1'b1, 12, 1'b0, 1'b1, 1'b0, 1};   // clean release
        vecs[3] = '{1'b0,  2, 1'b0, 1'b0, 1'b0, 1};   // bounce low 2
        vecs[4] = '{1'b1,  1, 1'b0, 1'b0, 1'b0, 1};   // bounce high 1
        vecs[5] = '{1'b0,  2, 1'b0, 1'b0, 1'b0, 1};   // bounce low 2
        vecs[6] = '{1'b1, 10, 1'b0, 1'b0, 1'b0, 1};   // settle released

        rst_n = 1'b0;
        btn_n = 1'b1;
        repeat (3) step();
        check("reset_level", int'(btn_level), 0);
        check("reset_press", int'(press_pulse), 0);
        check("reset_release", int'(release_pulse), 0);
        check("reset_repeat", int'(repeat_pulse), 0);
        check("reset_count", int'(press_count), 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            c0 = cyc + 1;
            if (vecs[i].exp_press) expect_at(c0 + c_LAT, 1);
            if (vecs[i].exp_rel)   expect_at(c0 + c_LAT, 2);
            btn_n = vecs[i].btn;
            repeat (vecs[i].hold) step();
            check("vec_level", int'(btn_level), int'(vecs[i].exp_level));
            check("vec_count", int'(press_count), vecs[i].exp_count);
        end

        // Long hold: auto-repeat at press+10, +13, ... while PRESSED
        c0 = cyc + 1;
        expect_at(c0 + c_LAT, 1);
`ifdef BUTTON_AUTOREPEAT_EN
        for (int k = c_LAT + 10; k <= 36; k += 3) expect_at(c0 + k, 3);
`endif
        btn_n = 1'b0;
        repeat (34) step();
        check("hold_level", int'(btn_level), 1);
        check("hold_count", int'(press_count), 2);
        c1 = cyc + 1;
        expect_at(c1 + c_LAT, 2);
        btn_n = 1'b1;
        repeat (12) step();
        check("hold_rel_level", int'(btn_level), 0);
        check("hold_rel_count", int'(press_count), 2);

        // Reset in the middle of PRESS_WAIT with the button held
        btn_n = 1'b0;
        repeat (4) step();
        rst_n = 1'b0;
        repeat (2) step();
        check("midrst_level", int'(btn_level), 0);
        check("midrst_count", int'(press_count), 0);
        c0 = cyc + 1;
        expect_at(c0 + c_LAT, 1);
        rst_n = 1'b1;
        repeat (12) step();
        check("postrst_level", int'(btn_level), 1);
        check("postrst_count", int'(press_count), 1);
        c1 = cyc + 1;
        expect_at(c1 + c_LAT, 2);
        btn_n = 1'b1;
        repeat (10) step();

        // Clean reset, then 256 presses to exercise the count wrap
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        check("wrap_start_count", int'(press_count), 0);
        for (int n = 0; n < 256; n++) begin
            c0 = cyc + 1;
            expect_at(c0 + c_LAT, 1);
            btn_n = 1'b0;
            repeat (9) step();
            c1 = cyc + 1;
            expect_at(c1 + c_LAT, 2);
            btn_n = 1'b1;
            repeat (9) step();
            if (n == 254) check("count_255", int'(press_count), 255);
        end
        check("count_wrap", int'(press_count), 0);
        check("wrap_level", int'(btn_level), 0);

        repeat (5) step();
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_debounce.md
BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000, is the number of stable cycles required to accept a level change (20 ms at 12 MHz); legal range 2..2^20-1.
REQ-002 Parameter REPEAT_DELAY, default 6000000, is the cycles held before the first auto-repeat (0.5 s).
REQ-003 Parameter REPEAT_PERIOD, default 1200000, is the cycles between subsequent auto-repeats (0.1 s).
REQ-004 clk  input  1  12 MHz system clock; all logic on its rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 btn_n  input  1  raw, asynchronous, bouncing pushbutton; low = pressed.
REQ-007 btn_level  output  1  debounced level; 1 = pressed.
REQ-008 press_pulse  output  1  one-cycle strobe on an accepted press.
REQ-009 release_pulse  output  1  one-cycle strobe on an accepted release.
REQ-010 repeat_pulse  output  1  one-cycle strobe per auto-repeat while held.
REQ-011 step_pulse  output  1  press_pulse OR repeat_pulse; the count-enable for the downstream LED counter.
REQ-012 press_count  output  8  accepted presses modulo 256.

Function
REQ-013 btn_n shall pass through a 2-flop synchronizer; no other logic shall sample btn_n directly.
REQ-014 The FSM shall have four states: IDLE (released), PRESS_WAIT, PRESSED, REL_WAIT.
REQ-015 IDLE: a synchronized press moves to PRESS_WAIT and clears the stable counter.
REQ-016 PRESS_WAIT: the counter increments each cycle while pressed; a sample reading released returns to IDLE and discards the count.
REQ-017 PRESS_WAIT: when the counter reaches DEBOUNCE_CYCLES-1 while pressed, the FSM moves to PRESSED.
REQ-018 PRESS_WAIT to PRESSED shall set btn_level=1, pulse press_pulse for exactly one cycle and increment press_count.
REQ-019 REL_WAIT mirrors PRESS_WAIT for release: an aborted release returns to PRESSED with no pulse; an accepted release enters IDLE, sets btn_level=0 and pulses release_pulse once.
REQ-020 PRESSED: a synchronized release moves to REL_WAIT and clears the counter.
REQ-021 Latency: from the first clk edge sampling btn_n low (stable) to press_pulse high is DEBOUNCE_CYCLES+3 edges; release is symmetric.
REQ-022 All outputs shall be registered; btn_level changes in the same cycle as its pulse.
REQ-023 press_count shall wrap 255 to 0 with no flag.
REQ-024 Stable counter width shall be clog2(DEBOUNCE_CYCLES); it shall never wrap, saturating at its terminal count.
REQ-025 At most one of press_pulse, release_pulse and repeat_pulse shall be high in any cycle.

Reset
REQ-026 While rst_n=0 at a clk edge, sync flops shall load 1 (released), FSM to IDLE, counters to 0, and all outputs to 0.
REQ-027 Reset asserted mid-debounce or mid-hold shall abandon the operation and emit no pulse; after release, a held button needs a full DEBOUNCE_CYCLES qualification before press_pulse.

Configuration
REQ-028 Macro BUTTON_AUTOREPEAT_EN, when defined, shall enable auto-repeat: in PRESSED, repeat_pulse fires REPEAT_DELAY cycles after press_pulse, then every REPEAT_PERIOD cycles until leaving PRESSED.
REQ-029 During REL_WAIT the repeat timer shall freeze; an aborted release resumes it without a pulse, and repeats never increment press_count.
REQ-030 Without BUTTON_AUTOREPEAT_EN, the repeat timer shall not be synthesized, repeat_pulse shall be tied to 0, and the port shall remain present.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-031 Reset, then btn_n held 1 for 20 cycles -> all outputs 0, press_count=0.
REQ-032 btn_n driven low and held -> press_pulse high for one cycle exactly 7 edges after the first low sample; btn_level=1; press_count=1.
REQ-033 Bounce low 2 cycles, high 1, low 2, high -> no press_pulse, btn_level stays 0.
REQ-034 With BUTTON_AUTOREPEAT_EN, hold for 30 cycles after press_pulse -> repeat_pulse at +10, +13, +16, ...; step_pulse matches press_pulse OR repeat_pulse; without the macro, repeat_pulse stays 0.
REQ-035 Perform 256 clean presses -> press_count returns to 0 and each press gives one press_pulse and one release_pulse.
REQ-036 rst_n pulsed low 2 cycles into PRESS_WAIT with btn_n held low -> no pulse during reset; press_pulse occurs 7 edges after rst_n returns high.
